// File: rtl/track_mixer.sv
// track_mixer
//   Mixes CHANNELS signed tracks into one signed sample per sample strobe.
//   Each accepted sample_tick issues a one-cycle mrd read pulse to the mix
//   FIFOs. The mixer then waits two cycles of FIFO read latency and
//   accumulates one gain-scaled channel per cycle. It finishes by emitting
//   dout together with a one-cycle dout_valid pulse.
//
// Build option:
//   TRACK_MIXER_SATURATE_EN - clamp the result to the WORD_WIDTH signed
//                             range. When undefined, the result wraps.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   enable       - mixing active; dropping it aborts the current sample
//   sample_tick  - one-cycle sample-rate strobe
//   mdout        - per-channel FIFO outputs, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
//   mrd          - FIFO read request, high for exactly one cycle per sample
//   gains        - per-channel unsigned gain, 2^(GAIN_WIDTH-1) = unity
//   mute         - bit k forces channel k's contribution to zero
//   dout         - mixed sample, held between updates
//   dout_valid   - one-cycle pulse when dout updates
//   busy         - FSM is not idle
//   overrun      - sticky: a tick arrived while busy; cleared by rst or enable=0
module track_mixer #(
    parameter int WORD_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           sample_tick,
    input  logic [CHANNELS*WORD_WIDTH-1:0] mdout,
    output logic                           mrd,
    input  logic [CHANNELS*GAIN_WIDTH-1:0] gains,
    input  logic [CHANNELS-1:0]            mute,
    output logic [WORD_WIDTH-1:0]          dout,
    output logic                           dout_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int PROD_W = WORD_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = WORD_WIDTH + GAIN_WIDTH + $clog2(CHANNELS) + 1;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT1,
        WAIT2,
        ACCUM,
        OUT
    } state_t;

    state_t state, state_next;

    logic        [IDX_W-1:0]      idx;
    logic signed [ACC_W-1:0]      acc;
    logic        [GAIN_WIDTH-1:0] gain_sh [CHANNELS];
    logic        [CHANNELS-1:0]   mute_sh;

    logic signed [WORD_WIDTH-1:0] samp [CHANNELS];
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      shifted;
    logic        [WORD_WIDTH-1:0] result;

    // Next-state logic; dropping enable returns to IDLE from any state.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample_tick) state_next = REQ;
                REQ:     state_next = WAIT1;
                WAIT1:   state_next = WAIT2;
                WAIT2:   state_next = ACCUM;
                ACCUM:   if (idx == LAST_IDX) state_next = OUT;
                OUT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign mrd  = (state == REQ);
    assign busy = (state != IDLE);

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            samp[k] = mdout[k*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // Gain is zero-extended by one bit so it multiplies as a non-negative signed value.
    always_comb begin
        prod = '0;
        if (!mute_sh[idx]) begin
            prod = PROD_W'(samp[idx]) * PROD_W'($signed({1'b0, gain_sh[idx]}));
        end
    end

    // The final channel's sum feeds the result directly, so dout is ready in OUT.
    assign sum     = acc + ACC_W'(prod);
    assign shifted = sum >>> (GAIN_WIDTH - 1);

`ifdef TRACK_MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};

    always_comb begin
        result = shifted[WORD_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[WORD_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[WORD_WIDTH-1:0];
        end
    end
`else
    assign result = shifted[WORD_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            mute_sh    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                gain_sh[k] <= '0;
            end
        end else begin
            state      <= state_next;
            dout_valid <= 1'b0;

            if (!enable) begin
                overrun <= 1'b0;
            end else if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable && sample_tick) begin
                        acc     <= '0;
                        idx     <= '0;
                        mute_sh <= mute;
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            gain_sh[k] <= gains[k*GAIN_WIDTH +: GAIN_WIDTH];
                        end
                    end
                end
                ACCUM: begin
                    if (enable) begin
                        acc <= sum;
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            dout       <= result;
                            dout_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_track_mixer.sv
// Testbench for track_mixer (CHANNELS=4, WORD_WIDTH=16, GAIN_WIDTH=8).
// Expected mixes come from a behavioural model computed when a sample is
// started; a negedge monitor pops them as dout_valid pulses.
module tb_track_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_tick;
    logic [63:0] mdout;
    logic        mrd;
    logic [31:0] gains;
    logic [3:0]  mute;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int mrd_cnt      = 0;
    int valid_cnt    = 0;

    int          smp [4];
    int          gn  [4];
    logic [3:0]  mu;
    logic [15:0] sb [$];
    logic [15:0] last_exp = '0;

    track_mixer #(
        .WORD_WIDTH(16),
        .CHANNELS  (4),
        .GAIN_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sample_tick(sample_tick),
        .mdout      (mdout),
        .mrd        (mrd),
        .gains      (gains),
        .mute       (mute),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer and pulse counters.
    always @(negedge clk) begin
        if (mrd === 1'b1) mrd_cnt++;
        if (dout_valid === 1'b1) begin
            valid_cnt++;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_valid: dout=%0d with nothing expected", $signed(dout));
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (dout !== e) begin
                    tests_failed++;
                    $display("FAIL sb_dout: got %0d expected %0d", $signed(dout), $signed(e));
                end
            end
        end
    end

    function automatic logic [15:0] model_mix();
        longint acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (!mu[k]) acc += longint'(smp[k]) * longint'(gn[k]);
        end
        acc = acc >>> 7;
`ifdef TRACK_MIXER_SATURATE_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] s, g;
            s = smp[k];
            g = gn[k];
            mdout[k*16 +: 16] = s[15:0];
            gains[k*8 +: 8]   = g[7:0];
        end
        mute = mu;
    endtask

    task automatic expect_mix();
        last_exp = model_mix();
        sb.push_back(last_exp);
    endtask

    // Tick sampled at edge T; returns at the negedge inside cycle T+1.
    task automatic pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic run_mix();
        drive();
        expect_mix();
        pulse_tick();
        repeat (8) @(negedge clk);
    endtask

    task automatic check_sb_empty(input string name);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_sb_pending: %0d outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int m0;
        rst = 1'b1; enable = 1'b1; sample_tick = 1'b0;
        mdout = '0; gains = '0; mute = '0;
        m0 = mrd_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample_tick = ~sample_tick;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        tests_run++;
        if ({mrd, dout, dout_valid, busy, overrun} !== 20'd0 || mrd_cnt != m0) begin
            tests_failed++;
            $display("FAIL reset_outputs: mrd=%b dout=%h valid=%b busy=%b ovr=%b mrd_pulses=%0d, expected all 0",
                     mrd, dout, dout_valid, busy, overrun, mrd_cnt - m0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({mrd, dout, dout_valid, busy, overrun} !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: mrd=%b dout=%h valid=%b busy=%b ovr=%b, expected all 0",
                     mrd, dout, dout_valid, busy, overrun);
        end
    endtask

    task automatic test_unity();
        smp = '{1000, 2000, -500, 0};
        gn  = '{128, 128, 128, 128};
        mu  = 4'b0000;
        drive();
        expect_mix();
        pulse_tick();
        tests_run++;
        if (mrd !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL unity_mrd_t1: mrd=%b busy=%b expected 1 1", mrd, busy);
        end
        for (int n = 2; n <= 9; n++) begin
            @(negedge clk);
            tests_run++;
            if (mrd !== 1'b0 || dout_valid !== (n == 8)) begin
                tests_failed++;
                $display("FAIL unity_t%0d: mrd=%b valid=%b expected 0 %0d", n, mrd, dout_valid, n == 8);
            end
            if (n == 8) begin
                tests_run++;
                if (dout !== 16'd2500) begin
                    tests_failed++;
                    $display("FAIL unity_dout: got %0d expected 2500", $signed(dout));
                end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity_idle: busy=%b expected 0", busy);
        end
        check_sb_empty("unity");
    endtask

    task automatic test_saturate();
        smp = '{30000, 30000, 30000, 30000};
        gn  = '{128, 128, 128, 128};
        mu  = 4'b0000;
        run_mix();
        smp = '{-30000, -30000, -30000, -30000};
        run_mix();
        check_sb_empty("saturate");
    endtask

    task automatic test_gain_mute();
        smp = '{1001, 12345, -7777, 20000};
        gn  = '{64, 200, 255, 17};
        mu  = 4'b1110;
        run_mix();
        smp[0] = -1001;
        run_mix();
        mu = 4'b1111;
        run_mix();
        // Gain/mute changes while accumulating must not affect the sample.
        smp[0] = 1001;
        mu = 4'b1110;
        drive();
        expect_mix();
        pulse_tick();
        repeat (3) @(negedge clk);
        gains = '1;
        mute  = '0;
        repeat (5) @(negedge clk);
        check_sb_empty("gain_mute");
    endtask

    task automatic test_overrun();
        int m0, v0;
        smp = '{300, -40, 7, 1234};
        gn  = '{128, 32, 255, 100};
        mu  = 4'b0000;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_initial: got %b expected 0", overrun);
        end
        drive();
        expect_mix();
        m0 = mrd_cnt;
        v0 = valid_cnt;
        pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (mrd_cnt - m0 != 1 || valid_cnt - v0 != 1 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulses: mrd=%0d valid=%0d ovr=%b expected 1 1 1",
                     mrd_cnt - m0, valid_cnt - v0, overrun);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
        enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        enable = 1'b1;
        check_sb_empty("overrun");
    endtask

    task automatic test_abort();
        int v0;
        logic [15:0] held;
        held = last_exp;
        smp = '{-9000, 4000, 111, -2};
        gn  = '{90, 128, 255, 1};
        mu  = 4'b0100;
        drive();
        v0 = valid_cnt;
        pulse_tick();
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mrd !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: busy=%b mrd=%b expected 0 0", busy, mrd);
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (valid_cnt != v0 || dout !== held) begin
            tests_failed++;
            $display("FAIL abort_hold: valid_pulses=%0d dout=%0d expected 0 %0d",
                     valid_cnt - v0, $signed(dout), $signed(held));
        end
        enable = 1'b1;
        @(negedge clk);
        run_mix();
        check_sb_empty("abort");
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturate();
        test_gain_mute();
        test_overrun();
        test_abort();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
